hc138_scan_driver: RTL
======================

# hc138_scan_driver

Sequencer sitting directly upstream of the 74HC138-style 3-to-8 decoder: it generates the 3-bit channel address and the three enable lines (EnableB0, EnableB1, Enable2) that drive the decoder. It cycles through a programmable set of channels, holds each one active for a programmable dwell time, and inserts break-before-make blanking between channels so that two decoder outputs never glitch active together. Typical uses are multiplexed LED/7-segment scanning and row strobing.

## Interface
- DWELL_W, 8: width of the dwell-time input and the internal dwell counter.
- BLANK_CYCLES, 2: decoder-disabled cycles inserted before every channel activation; must be ≥1.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle request to begin scanning; sampled only in IDLE.
- stop  in  1  one-cycle request to end scanning; latched internally.
- dwell  in  DWELL_W  active cycles per channel; sampled on entry to ACTIVE; 0 is treated as 1.
- chan_mask  in  8  enabled channels; bit i enables address i.
- addr  out  3  channel address to the decoder, {NumberBit2,NumberBit1,NumberBit0}.
- en_b0  out  1  decoder EnableB0; the decoder is enabled when this is 0.
- en_b1  out  1  decoder EnableB1; the decoder is enabled when this is 0.
- en2  out  1  decoder Enable2; the decoder is enabled when this is 1.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse when the scan wraps back to the lowest enabled channel.

## Operation
- All outputs are registered. In the reset state: addr=0, en_b0=1, en_b1=1, en2=0, busy=0, frame_done=0, stop latch cleared, state IDLE.
- Decoder-enabled condition: en_b0=0, en_b1=0 and en2=1. Only the ACTIVE state drives this condition. All other states drive en_b0=1, en_b1=1, en2=0.
- The FSM has three states: IDLE, BLANK and ACTIVE.
- IDLE
  - If start=1, stop=0 and chan_mask≠0: move to BLANK, set addr to the lowest set bit of chan_mask, clear the blank counter, and set busy.
  - If start=1 and stop=1 in the same cycle: stop wins, and the block stays in IDLE.
  - If chan_mask=0: start is ignored.
- BLANK
  - addr is held. After exactly BLANK_CYCLES cycles the FSM moves to ACTIVE and loads the dwell counter from max(dwell,1).
  - If a stop is pending, the FSM aborts to IDLE on the next edge: addr←0 and busy←0.
- ACTIVE
  - The decoder is enabled for exactly max(dwell,1) cycles. At the end of the final dwell cycle, exactly one of the following applies:
    - Stop pending: go to IDLE, addr←0, clear the stop latch.
    - chan_mask=0 (sampled now): go to IDLE.
    - Otherwise: next = the first set bit of chan_mask searched from addr+1 upward, with mod-8 wrap. Go to BLANK with addr←next. If next≤addr (a wrap, including the single-channel case), pulse frame_done in the same cycle that addr updates.
- stop received in ACTIVE is latched and honoured only at the end of the current dwell; a started channel always completes.
- Changes to chan_mask take effect only at the next-channel decision. Changes to dwell take effect only at the next entry to ACTIVE.
- start received while busy is ignored.
- An rst_n assertion at any point, including mid-dwell, returns all outputs to their reset values immediately (asynchronously).

## Timing
- Edge 0 samples start; the FSM is in BLANK from edge 0 onward with addr valid.
- The decoder is enabled from edge BLANK_CYCLES through edge BLANK_CYCLES+D−1, where D=max(dwell,1).
- Per-channel period is BLANK_CYCLES+D cycles.
- A full frame is N·(BLANK_CYCLES+D) cycles, where N is the number of set bits in chan_mask.
- addr never changes while the decoder is enabled. Enables deassert on the same edge that addr changes.
- frame_done is high for exactly one cycle per wrap and never high in IDLE.
- Stop latency:
  - Stop in BLANK: busy falls 1 cycle after stop is sampled.
  - Stop in ACTIVE: busy falls on the edge ending the current dwell.

## Test plan
- Reset: hold rst_n=0 with random inputs → addr=0, en_b0=1, en_b1=1, en2=0, busy=0, frame_done=0. Release rst_n, pulse start with mask=0 → block stays idle.
- Basic scan: BLANK_CYCLES=2, dwell=3, mask=8'b0000_0101, pulse start → decoder sequence is (disabled, addr 0) ×2, (enabled, addr 0) ×3, (disabled, addr 2) ×2, (enabled, addr 2) ×3, then addr returns to 0 with a one-cycle frame_done. The period is 10 cycles.
- Edge values: dwell=0 with mask=8'h80 → each channel is active for 1 cycle, addr stays 7, and frame_done pulses every 3 cycles.
- Stop handling:
  - Stop asserted in the 2nd cycle of a 3-cycle dwell → the dwell completes, then busy drops and addr=0.
  - Stop asserted in BLANK → IDLE on the next cycle with no enabled cycle.
- Mask change mid-scan: mask changed from 8'hFF to 8'h10 while active on addr 2 → the next channel is 4, and frame_done does not pulse. Mask changed to 0 → IDLE at the end of the current dwell.
- Asynchronous reset mid-dwell: assert rst_n between clock edges → outputs clear without waiting for a clock edge. A subsequent start restarts from the lowest set bit of the mask.

Source files
------------

// File: rtl/hc138_scan_driver.sv
// Scan sequencer for a 74HC138-style 3-to-8 decoder: steps through the enabled
// channels with break-before-make blanking before each activation.
module hc138_scan_driver #(
  parameter int DWELL_W      = 8,
  parameter int BLANK_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [7:0]         chan_mask,
  output logic [2:0]         addr,
  output logic               en_b0,
  output logic               en_b1,
  output logic               en2,
  output logic               busy,
  output logic               frame_done
);

  localparam int BW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [BW-1:0] BLANK_LAST = BW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ACTIVE} state_t;

  state_t             state_q, state_d;
  logic [2:0]         addr_d;
  logic [BW-1:0]      blank_q, blank_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               stop_lat_q, stop_lat_d;
  logic               frame_d;
  logic               stop_pend;
  logic [2:0]         nxt;

  // First set bit of m strictly after cur, wrapping mod 8; cur itself is
  // checked last so a single-channel mask returns cur.
  function automatic logic [2:0] next_chan(input logic [7:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic [2:0] idx;
    logic       found;
    r     = cur;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = cur + 3'(i);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  assign stop_pend = stop | stop_lat_q;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr;
    blank_d    = blank_q;
    dwell_d    = dwell_q;
    stop_lat_d = stop_lat_q;
    frame_d    = 1'b0;
    nxt        = next_chan(chan_mask, addr);
    case (state_q)
      IDLE: begin
        stop_lat_d = 1'b0;
        if (start && !stop && (chan_mask != 8'h00)) begin
          state_d = BLANK;
          addr_d  = next_chan(chan_mask, 3'd7);
          blank_d = '0;
        end
      end
      BLANK: begin
        if (stop_pend) begin
          state_d    = IDLE;
          addr_d     = 3'd0;
          stop_lat_d = 1'b0;
        end else if (blank_q == BLANK_LAST) begin
          state_d = ACTIVE;
          dwell_d = (dwell == '0) ? DWELL_W'(1) : dwell;
        end else begin
          blank_d = blank_q + BW'(1);
        end
      end
      ACTIVE: begin
        stop_lat_d = stop_pend;
        if (dwell_q <= DWELL_W'(1)) begin
          if (stop_pend || (chan_mask == 8'h00)) begin
            state_d    = IDLE;
            addr_d     = 3'd0;
            stop_lat_d = 1'b0;
          end else begin
            state_d = BLANK;
            addr_d  = nxt;
            blank_d = '0;
            frame_d = (nxt <= addr);
          end
        end else begin
          dwell_d = dwell_q - DWELL_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        addr_d     = 3'd0;
        stop_lat_d = 1'b0;
      end
    endcase
  end

  // Outputs are registered from the next-state so they align with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr       <= 3'd0;
      blank_q    <= '0;
      dwell_q    <= '0;
      stop_lat_q <= 1'b0;
      en_b0      <= 1'b1;
      en_b1      <= 1'b1;
      en2        <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr       <= addr_d;
      blank_q    <= blank_d;
      dwell_q    <= dwell_d;
      stop_lat_q <= stop_lat_d;
      en_b0      <= (state_d != ACTIVE);
      en_b1      <= (state_d != ACTIVE);
      en2        <= (state_d == ACTIVE);
      busy       <= (state_d != IDLE);
      frame_done <= frame_d;
    end
  end

endmodule
